// File: rtl/graphics_pkg.sv
// Shared display-path types: RGB pixel, colour selector, pipeline sideband.
// Default resolution constants and pixel colour helpers.
package graphics_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    GRAY  = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10,
    BLUE  = 2'b11
  } color_sel_t;

  typedef struct packed {
    logic       valid;
    logic       in_region;
    logic       sop;
    logic       eop;
    color_sel_t col;
    logic       tp;
    logic [2:0] bar;
  } side_t;

  function automatic rgb_t expand(
    input color_sel_t c,
    input logic [7:0] p
  );
    rgb_t v;
    v = '0;
    unique case (c)
      GRAY:  v = '{p, p, p};
      RED:   v.r = p;
      GREEN: v.g = p;
      BLUE:  v.b = p;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic rgb_t bars(input logic [2:0] b);
    rgb_t v;
    v.r = b[2] ? 8'hFF : 8'h00;
    v.g = b[1] ? 8'hFF : 8'h00;
    v.b = b[0] ? 8'hFF : 8'h00;
    return v;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO for the pixel output path.
// Exposes its fill level so the issue stage can count credits.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop)  rd <= inc(rd);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign dout = mem[rd];

endmodule

// File: rtl/frame_streamer.sv
// Raster-scan ROM pixel source with SOP/EOP framing and credit backpressure.
// FRAME_STREAMER_TEST_PATTERN_EN adds a test_pattern input (colour bars).
module frame_streamer
  import graphics_pkg::*;
#(
  parameter int          H_RES       = H_RES_DEF,
  parameter int          V_RES       = V_RES_DEF,
  parameter int          IMG_W       = IMG_W_DEF,
  parameter int          IMG_H       = IMG_H_DEF,
  parameter int          ADDR_W      = 19,
  parameter int          MEM_LATENCY = 2,
  parameter int          DEPTH       = 4,
  parameter logic [23:0] BORDER      = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              image_selector,
  input  logic [1:0]        color_selector,
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [23:0]       out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_empty
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] IMG_SZ =
    ADDR_W'(IMG_W * IMG_H);

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              img_q;
  color_sel_t        col_q;
  logic              tp_q;
  logic              tp_in;
  side_t             p_q;
  side_t             sr_q [MEM_LATENCY];
  side_t             side_n;
  side_t             wb;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic [CW:0]       owned;
  logic              issue;
  logic              pop;
  logic              first;
  logic              x_last;
  logic              y_last;
  logic              img_s;
  rgb_t              pix;
  logic [25:0]       fifo_dout;

`ifdef FRAME_STREAMER_TEST_PATTERN_EN
  assign tp_in = test_pattern;
`else
  assign tp_in = 1'b0;
`endif

  assign pop = out_valid && out_ready;

  // Reads in the pipe plus FIFO entries never exceed DEPTH
  always_comb begin
    inflight = (CW + 1)'(p_q.valid);
    for (int i = 0; i < MEM_LATENCY; i++)
      inflight = inflight + (CW + 1)'(sr_q[i].valid);
  end

  assign owned = {1'b0, fifo_count} + inflight
               - (CW + 1)'(pop);
  assign issue = owned < (CW + 1)'(DEPTH);

  assign first  = (x == '0) && (y == '0);
  assign x_last = x == XW'(H_RES - 1);
  assign y_last = y == YW'(V_RES - 1);
  assign img_s  = first ? image_selector : img_q;
  assign base   = img_s ? IMG_SZ : '0;

  always_comb begin
    side_n           = '0;
    side_n.valid     = issue;
    side_n.in_region = (int'(x) < IMG_W)
                    && (int'(y) < IMG_H);
    side_n.sop       = first;
    side_n.eop       = x_last && y_last;
    side_n.col       = first
                     ? color_sel_t'(color_selector)
                     : col_q;
    side_n.tp        = first ? tp_in : tp_q;
    side_n.bar       = 3'(int'(x) >> 5);
    addr_n           = base;
    if (side_n.in_region)
      addr_n = base
             + ADDR_W'(y) * ADDR_W'(IMG_W)
             + ADDR_W'(x);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      mem_address <= '0;
      p_q         <= '0;
      img_q       <= 1'b0;
      col_q       <= GRAY;
      tp_q        <= 1'b0;
    end else begin
      p_q <= side_n;
      if (issue) begin
        mem_address <= addr_n;
        if (first) begin
          img_q <= image_selector;
          col_q <= color_sel_t'(color_selector);
          tp_q  <= tp_in;
        end
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++)
        sr_q[i] <= '0;
    end else begin
      sr_q[0] <= p_q;
      for (int i = 1; i < MEM_LATENCY; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign wb = sr_q[MEM_LATENCY-1];

  always_comb begin
    pix = BORDER;
    if (wb.in_region)
      pix = wb.tp ? bars(wb.bar)
                  : expand(wb.col, mem_data);
  end

  stream_fifo #(
    .DEPTH (DEPTH),
    .W     (26)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wb.valid),
    .din   ({pix, wb.sop, wb.eop}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign out_valid = fifo_count != '0;
  assign out_data  = out_valid ? fifo_dout[25:2] : '0;
  assign out_sop   = out_valid && fifo_dout[1];
  assign out_eop   = out_valid && fifo_dout[0];
  assign out_empty = 1'b0;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer on a small 8x4 raster with a 4x2 image.
// Expected pixels come from a raster/arithmetic model of the frame.
module tb_frame_streamer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int N  = H * V;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        image_selector = 1'b0;
  logic [1:0]  color_selector = 2'b00;
  logic [18:0] mem_address;
  logic [7:0]  mem_data = 8'h00;
  logic [18:0] a1 = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_empty;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [25:0] q[$];
  int cq[$];

  always #5 clk = ~clk;

  frame_streamer #(
    .H_RES       (H),
    .V_RES       (V),
    .IMG_W       (IW),
    .IMG_H       (IH),
    .ADDR_W      (19),
    .MEM_LATENCY (2),
    .DEPTH       (4),
    .BORDER      (24'h000000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .image_selector (image_selector),
    .color_selector (color_selector),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_empty      (out_empty)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ROM[a] = a, two-cycle read latency
  always @(posedge clk) begin
    a1       <= mem_address;
    mem_data <= 8'(a1);
  end

  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      q.push_back({out_data, out_sop, out_eop});
      cq.push_back(cyc);
    end

  function automatic logic [25:0] exp_pix(
    input int i, input bit img, input int c
  );
    int x;
    int y;
    logic [7:0]  p;
    logic [23:0] rgb;
    x = i % H;
    y = i / H;
    p = 8'((img ? IW * IH : 0) + y * IW + x);
    if (x < IW && y < IH) begin
      case (c)
        0: rgb = {p, p, p};
        1: rgb = {p, 16'h0000};
        2: rgb = {8'h00, p, 8'h00};
        default: rgb = {16'h0000, p};
      endcase
    end else begin
      rgb = 24'h000000;
    end
    return {rgb, i == 0, i == N - 1};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    cq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk($sformatf("timeout_q%0d", n),
        32'(q.size() >= n), 32'd1);
  endtask

  task automatic cmp(
    input int n, input bit img,
    input int c0, input int c1
  );
    for (int i = 0; i < n; i++)
      chk($sformatf("pix%0d", i), 32'(q[i]),
          32'(exp_pix(i % N, img, (i < N) ? c0 : c1)));
  endtask

  initial begin
    int c;
    int guard;
    bit img;
    bit held_done;
    logic [25:0] h;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_sop", 32'(out_sop), 0);
    chk("rst_eop", 32'(out_eop), 0);
    chk("rst_empty", 32'(out_empty), 0);
    q.delete();
    cq.delete();
    reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("valid_e%0d", e),
          32'(out_valid), 32'(e == 3));
      if (e < 2)
        chk($sformatf("addr_e%0d", e),
            32'(mem_address), 32'(e));
    end
    wait_q(2 * N, 300);
    cmp(2 * N, 1'b0, 0, 0);
    chk("row0_p3", 32'(q[3][25:2]), 32'h030303);
    chk("row0_p4", 32'(q[4][25:2]), 32'h000000);
    chk("b2b_gap", 32'(cq[N] - cq[N-1]), 1);
    chk("thruput", 32'(cq[2*N-1] - cq[0]), 2 * N - 1);

    // colour change mid-frame
    image_selector = 1'b0;
    color_selector = 2'b00;
    do_reset();
    wait_q(10, 100);
    color_selector = 2'b01;
    wait_q(2 * N, 300);
    cmp(2 * N, 1'b0, 0, 1);
    chk("f1_p1", 32'(q[N+1][25:2]), 32'h010000);

    // second image
    c = $urandom_range(0, 3);
    image_selector = 1'b1;
    color_selector = 2'(c);
    do_reset();
    @(posedge clk);
    #1;
    chk("img1_addr0", 32'(mem_address), 8);
    wait_q(N, 200);
    cmp(N, 1'b1, c, c);
    chk("img1_p11",
        32'(q[11][25:18] | q[11][17:10] | q[11][9:2]), 15);

    // random backpressure with a 10-cycle stall
    img = 1'($urandom_range(0, 1));
    c = $urandom_range(0, 3);
    image_selector = img;
    color_selector = 2'(c);
    do_reset();
    guard = 0;
    held_done = 1'b0;
    while (q.size() < 2 * N && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
      if (q.size() >= 12 && !held_done) begin
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        h = {out_data, out_sop, out_eop};
        chk("hold_valid", 32'(out_valid), 1);
        repeat (9) begin
          @(posedge clk);
          #1;
          chk("hold_data",
              32'({out_data, out_sop, out_eop}), 32'(h));
        end
        held_done = 1'b1;
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    out_ready = 1'b1;
    chk("bp_done", 32'(q.size() >= 2 * N), 1);
    cmp(2 * N, img, c, c);

    // reset mid-frame
    image_selector = 1'b0;
    color_selector = 2'b00;
    do_reset();
    wait_q(14, 100);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    color_selector = 2'b10;
    q.delete();
    cq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_addr", 32'(mem_address), 0);
    wait_q(N, 200);
    chk("restart_sop", 32'(q[0][1]), 1);
    cmp(N, 1'b0, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
